pr_range_fetcher: RTL and testbench
===================================

Name: pr_range_fetcher

Overview:
Upstream feeder for the element read buffer. Accepts a command naming an element range [base, base+count), issues in-order line reads to the memory adapter, and realigns returned lines so that element `base` lands in slot 0. It writes output lines into the buffer with `last`/`bounds` on the final line. Used for CSR neighbour lists and rank-vector segments whose start index is not line-aligned.

Parameters:
FULL_WIDTH, 512, line width in bits (memory response and buffer write width)
WIDTH, 64, element width in bits; M = FULL_WIDTH/WIDTH, power of two, at most 128
ADDR_W, 32, width of element index and of line index
CNT_W, 32, width of element count
MAX_OUTSTANDING, 8, cap on line requests issued but not yet accepted back

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_base  in  ADDR_W  first element index
cmd_count  in  CNT_W  number of elements
mem_req_valid  out  1  line read request
mem_req_ready  in  1  adapter accepts request
mem_req_addr  out  ADDR_W  line index, base/M + j
mem_rsp_valid  in  1  line data present; responses arrive in request order
mem_rsp_ready  out  1  fetcher accepts line
mem_rsp_data  in  FULL_WIDTH  line; element k of the line is at bits [FULL_WIDTH-1-k*WIDTH -: WIDTH]
buf_wrreq  out  1  write one line to buffer
buf_wdata  out  FULL_WIDTH  realigned line, same element layout as mem_rsp_data
buf_last  out  1  final line of command, qualified by buf_wrreq
buf_bounds  out  8  valid elements in final line, range 1..M
buf_full  in  1  buffer cannot accept

Behaviour:
- Reset: synchronous and active-high. The block enters IDLE and clears all counters and the hold register. Reset values: cmd_ready=1; mem_req_valid=0; mem_rsp_ready=0; buf_wrreq=0; buf_last=0; buf_bounds=0; mem_req_addr=0; buf_wdata=0.
- Reset mid-operation: the command is abandoned and nothing further is written. The memory adapter shares rst and drops its in-flight responses.
- Command latch: a command is accepted on cmd_valid && cmd_ready. The block latches the following values:
  - off = base mod M
  - line0 = base / M
  - L_in = ceil((off+count)/M)
  - L_out = ceil(count/M)
  - fb = count - (L_out-1)*M
- Zero count: count==0 goes IDLE->DONE->IDLE. The block issues no requests and no writes, and cmd_ready returns 2 cycles after acceptance.
- States:
  - IDLE: waits for a command.
  - RUN: requests and responses active.
  - FLUSH: emits the final output from the hold register alone.
  - DONE: one cycle, then back to IDLE.
- Request side (RUN only):
  - mem_req_valid = req_cnt < L_in && (req_cnt - rsp_cnt) < MAX_OUTSTANDING.
  - req_cnt increments on handshake.
  - mem_req_addr = line0 + req_cnt, registered, stable while valid && !ready.
- Response side (RUN only):
  - mem_rsp_ready = rsp_cnt < L_in && !buf_full.
  - Accepted line j is stored in the hold register.
  - off==0: the accepted line is written through in the same cycle (buf_wrreq combinational with the handshake, buf_wdata = mem_rsp_data).
  - off!=0 and j>=1: output line j-1 is written = upper FULL_WIDTH bits of {hold, rsp} << (off*WIDTH).
  - off!=0 and j==0: nothing is written.
- Final line:
  - buf_last=1 and buf_bounds=fb on output line L_out-1; buf_bounds=0 on non-final writes.
  - Lanes beyond fb are don't-care.
  - After the last response: go to FLUSH if off!=0 and L_in==L_out, else go to DONE.
- FLUSH:
  - Writes {hold, 0} << (off*WIDTH), with last=1 and bounds=fb, on the first cycle where !buf_full.
  - Then goes to DONE.
- buf_full semantics: buf_wrreq is never asserted while buf_full=1. Because mem_rsp_ready is gated by !buf_full, no data is lost.
- Counters: req_cnt and rsp_cnt are CNT_W bits wide. The outstanding difference is computed at log2(MAX_OUTSTANDING)+1 bits.
- Arithmetic: M is a power of two, so div/mod are shift/mask.

Decomposition:
- Package pr_pkg holds:
  - localparam M and LOG_M
  - the state enum (IDLE, RUN, FLUSH, DONE)
  - functions line_of(idx), off_of(idx), lines_for(off, count)
- One sub-module is natural: pr_line_align. It is combinational, with inputs hi, lo and off, and output aligned line. It is shared by the RUN and FLUSH paths.

Test Plan:
Configuration M=8; memory model returns element value = its global index.
1. Aligned: base=16, count=16 -> requests lines 2,3; two writes with elems 16..23 and 24..31; second write has last=1, bounds=8; no FLUSH.
2. Single partial line: base=3, count=5 -> one request to line 0; one write via FLUSH with elems 3..7 in slots 0..4, last=1, bounds=5.
3. Unaligned spanning: base=5, count=10 -> requests lines 0,1; write 1 = elems 5..12, last=0; FLUSH write = elems 13,14, last=1, bounds=2.
4. Unaligned with no flush: base=6, count=4 -> requests lines 0,1; exactly one write = elems 6..9, last=1, bounds=4; FSM never enters FLUSH.
5. Backpressure and credit:
   - base=0, count=96 with mem_rsp_valid held low -> exactly 8 requests, then mem_req_valid=0.
   - Release, then hold buf_full=1 for 5 cycles mid-stream -> no buf_wrreq and mem_rsp_ready=0 during those cycles; all 12 lines arrive in order, the last with bounds=8.
6. Edge cases:
   - count=0 -> no requests or writes; cmd_ready=1 two cycles after acceptance.
   - rst asserted during case 3 after the first response -> next cycle cmd_ready=1 and all outputs at reset values.
   - A new command base=8, count=8 after the reset completes correctly.

Source files
------------

// File: rtl/pr_range_fetcher_pkg.sv
// Shared constants, FSM state type and index helpers
// for the element range fetcher.
package pr_pkg;

  localparam int PR_FULL_W = 512;
  localparam int PR_ELEM_W = 64;
  localparam int PR_ADDR_W = 32;
  localparam int PR_CNT_W  = 32;
  localparam int M         = PR_FULL_W / PR_ELEM_W;
  localparam int LOG_M     = $clog2(M);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  function automatic logic [PR_ADDR_W-1:0] line_of(
    input logic [PR_ADDR_W-1:0] idx
  );
    return idx >> LOG_M;
  endfunction

  function automatic logic [LOG_M-1:0] off_of(
    input logic [PR_ADDR_W-1:0] idx
  );
    return idx[LOG_M-1:0];
  endfunction

  // Lines touched by count elements starting at slot off.
  function automatic logic [PR_CNT_W-1:0] lines_for(
    input logic [LOG_M-1:0]    off,
    input logic [PR_CNT_W-1:0] count
  );
    logic [PR_CNT_W:0] t;
    t = {1'b0, count} + (PR_CNT_W+1)'(off)
      + (PR_CNT_W+1)'(M - 1);
    return PR_CNT_W'(t >> LOG_M);
  endfunction

endpackage

// File: rtl/pr_line_align.sv
// Element realigner: top line of {hi, lo} shifted
// left by off elements.
module pr_line_align #(
  parameter int  FULL_WIDTH = 512,
  parameter int  WIDTH      = 64,
  localparam int OFF_W      = $clog2(FULL_WIDTH / WIDTH)
) (
  input  logic [FULL_WIDTH-1:0] hi,
  input  logic [FULL_WIDTH-1:0] lo,
  input  logic [OFF_W-1:0]      off,
  output logic [FULL_WIDTH-1:0] aligned
);

  localparam int EW = $clog2(WIDTH);

  logic [OFF_W+EW-1:0] w_sh;

  assign w_sh    = {off, {EW{1'b0}}};
  assign aligned = FULL_WIDTH'(({hi, lo} << w_sh) >> FULL_WIDTH);

endmodule

// File: rtl/pr_range_fetcher.sv
// Range fetcher: issues in-order line reads and writes
// realigned lines so element base lands in slot 0.
module pr_range_fetcher
  import pr_pkg::*;
#(
  parameter int FULL_WIDTH      = PR_FULL_W,
  parameter int WIDTH           = PR_ELEM_W,
  parameter int ADDR_W          = PR_ADDR_W,
  parameter int CNT_W           = PR_CNT_W,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_base,
  input  logic [CNT_W-1:0]      cmd_count,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_req_addr,
  input  logic                  mem_rsp_valid,
  output logic                  mem_rsp_ready,
  input  logic [FULL_WIDTH-1:0] mem_rsp_data,
  output logic                  buf_wrreq,
  output logic [FULL_WIDTH-1:0] buf_wdata,
  output logic                  buf_last,
  output logic [7:0]            buf_bounds,
  input  logic                  buf_full
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  state_t                r_state;
  state_t                w_next;
  logic [LOG_M-1:0]      r_off;
  logic [ADDR_W-1:0]     r_addr;
  logic [CNT_W-1:0]      r_lin;
  logic [CNT_W-1:0]      r_lout;
  logic [CNT_W-1:0]      r_req_cnt;
  logic [CNT_W-1:0]      r_rsp_cnt;
  logic [7:0]            r_fb;
  logic [FULL_WIDTH-1:0] r_hold;

  logic [OW-1:0]         w_outs;
  logic                  w_req_ok;
  logic                  w_rsp_ok;
  logic                  w_req_fire;
  logic                  w_rsp_fire;
  logic                  w_rsp_last;
  logic                  w_wr_last;
  logic [CNT_W-1:0]      w_out_idx;
  logic [CNT_W-1:0]      w_lout;
  logic [FULL_WIDTH-1:0] w_al_lo;
  logic [FULL_WIDTH-1:0] w_aligned;

  assign w_outs   = OW'(r_req_cnt - r_rsp_cnt);
  assign w_req_ok = (r_state == RUN)
                 && (r_req_cnt < r_lin)
                 && (w_outs < OW'(MAX_OUTSTANDING));
  assign w_rsp_ok = (r_state == RUN)
                 && (r_rsp_cnt < r_lin)
                 && !buf_full;

  assign cmd_ready     = (r_state == IDLE);
  assign mem_req_valid = w_req_ok;
  assign mem_rsp_ready = w_rsp_ok;
  assign mem_req_addr  = r_addr;

  assign w_req_fire = w_req_ok && mem_req_ready;
  assign w_rsp_fire = w_rsp_ok && mem_rsp_valid;
  assign w_rsp_last = (r_rsp_cnt == r_lin - 1'b1);
  assign w_lout     = lines_for('0, cmd_count);

  // Unaligned ranges emit line j-1 when line j arrives.
  assign w_out_idx = (r_off == '0) ? r_rsp_cnt
                                   : r_rsp_cnt - 1'b1;
  assign w_wr_last = (w_out_idx == r_lout - 1'b1);
  assign w_al_lo   = (r_state == FLUSH) ? '0 : mem_rsp_data;

  pr_line_align #(
    .FULL_WIDTH (FULL_WIDTH),
    .WIDTH      (WIDTH)
  ) u_align (
    .hi      (r_hold),
    .lo      (w_al_lo),
    .off     (r_off),
    .aligned (w_aligned)
  );

  always_comb begin
    w_next     = r_state;
    buf_wrreq  = 1'b0;
    buf_wdata  = '0;
    buf_last   = 1'b0;
    buf_bounds = '0;
    unique case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_next = (cmd_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_rsp_fire) begin
          buf_wrreq = (r_off == '0) || (r_rsp_cnt != '0);
          if (buf_wrreq) begin
            buf_wdata = (r_off == '0) ? mem_rsp_data
                                      : w_aligned;
          end
          if (w_rsp_last) begin
            w_next = ((r_off != '0) && (r_lin == r_lout))
                   ? FLUSH : DONE;
          end
        end
      end
      FLUSH: begin
        if (!buf_full) begin
          buf_wrreq = 1'b1;
          buf_wdata = w_aligned;
          w_next    = DONE;
        end
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (buf_wrreq && w_wr_last) begin
      buf_last   = 1'b1;
      buf_bounds = r_fb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_off     <= '0;
      r_addr    <= '0;
      r_lin     <= '0;
      r_lout    <= '0;
      r_fb      <= '0;
      r_req_cnt <= '0;
      r_rsp_cnt <= '0;
      r_hold    <= '0;
    end else begin
      r_state <= w_next;
      if (cmd_valid && cmd_ready) begin
        r_off     <= off_of(cmd_base);
        r_addr    <= line_of(cmd_base);
        r_lin     <= lines_for(off_of(cmd_base), cmd_count);
        r_lout    <= w_lout;
        r_fb      <= 8'(cmd_count
                     - ((w_lout - 1'b1) << LOG_M));
        r_req_cnt <= '0;
        r_rsp_cnt <= '0;
      end
      if (w_req_fire) begin
        r_req_cnt <= r_req_cnt + 1'b1;
        r_addr    <= r_addr + 1'b1;
      end
      if (w_rsp_fire) begin
        r_rsp_cnt <= r_rsp_cnt + 1'b1;
        r_hold    <= mem_rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_pr_range_fetcher.sv
// Bench for pr_range_fetcher: in-order memory model whose
// elements equal their global index, checked per command.
module tb_pr_range_fetcher;

  localparam int FW = 512;
  localparam int EW = 64;
  localparam int NE = FW / EW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [31:0]   cmd_base;
  logic [31:0]   cmd_count;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [31:0]   mem_req_addr;
  logic          mem_rsp_valid;
  logic          mem_rsp_ready;
  logic [FW-1:0] mem_rsp_data;
  logic          buf_wrreq;
  logic [FW-1:0] buf_wdata;
  logic          buf_last;
  logic [7:0]    buf_bounds;
  logic          buf_full;

  pr_range_fetcher dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_base      (cmd_base),
    .cmd_count     (cmd_count),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rsp_data  (mem_rsp_data),
    .buf_wrreq     (buf_wrreq),
    .buf_wdata     (buf_wdata),
    .buf_last      (buf_last),
    .buf_bounds    (buf_bounds),
    .buf_full      (buf_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0]   memq[$];
  logic [31:0]   req_log[$];
  logic [FW-1:0] wr_data[$];
  logic          wr_last[$];
  logic [7:0]    wr_bnd[$];
  int            accepted;
  int            rsp_seen;
  int            full_viol;

  bit          g_rst = 1'b1;
  bit          g_cmd_valid = 1'b0;
  logic [31:0] g_base = '0;
  logic [31:0] g_count = '0;
  bit          g_rsp_en = 1'b1;
  bit          g_rnd = 1'b1;
  bit          g_full = 1'b0;
  bit          g_rnd_full = 1'b0;

  function automatic logic [FW-1:0] line_data(input logic [31:0] ln);
    logic [FW-1:0] d;
    d = '0;
    for (int k = 0; k < NE; k++)
      d[FW-1-k*EW -: EW] = 64'(ln * NE + 32'(k));
    return d;
  endfunction

  task automatic clear_logs();
    req_log.delete();
    wr_data.delete();
    wr_last.delete();
    wr_bnd.delete();
    accepted  = 0;
    rsp_seen  = 0;
    full_viol = 0;
  endtask

  // One clock: drive at negedge, observe just after.
  task automatic cycle();
    @(negedge clk);
    rst       = g_rst;
    cmd_valid = g_cmd_valid;
    cmd_base  = g_base;
    cmd_count = g_count;
    mem_req_ready = g_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    buf_full = g_full || (g_rnd_full && $urandom_range(0, 4) == 0);
    if (memq.size() > 0 && g_rsp_en && !g_rst &&
        (!g_rnd || $urandom_range(0, 3) != 0)) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = line_data(memq[0]);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
    #1;
    if (g_rst) begin
      memq.delete();
    end else begin
      if (cmd_valid && cmd_ready) begin
        accepted++;
        g_cmd_valid = 1'b0;
      end
      if (mem_req_valid && mem_req_ready) begin
        memq.push_back(mem_req_addr);
        req_log.push_back(mem_req_addr);
      end
      if (mem_rsp_valid && mem_rsp_ready) begin
        void'(memq.pop_front());
        rsp_seen++;
      end
      if (buf_wrreq) begin
        wr_data.push_back(buf_wdata);
        wr_last.push_back(buf_last);
        wr_bnd.push_back(buf_bounds);
        if (buf_full) full_viol++;
      end
    end
  endtask

  // Compare everything logged for one command with the
  // element-level view of the range.
  task automatic score(input string name, input int base, input int count);
    int nreq, nwr, n, bad;
    logic [EW-1:0] got, want;
    nreq = (count == 0) ? 0 : (base + count - 1) / NE - base / NE + 1;
    bad = -1;
    if (req_log.size() == nreq)
      foreach (req_log[i])
        if (req_log[i] !== 32'(base / NE + i)) bad = i;
    checks++;
    if (req_log.size() != nreq || bad >= 0) begin
      failures++;
      $display("FAIL %s requests: got %0d lines (bad idx %0d), want %0d from line %0d",
               name, req_log.size(), bad, nreq, base / NE);
    end
    nwr = (count + NE - 1) / NE;
    checks++;
    if (wr_data.size() != nwr) begin
      failures++;
      $display("FAIL %s write count: got %0d want %0d", name, wr_data.size(), nwr);
    end else begin
      for (int w = 0; w < nwr; w++) begin
        n = (w == nwr - 1) ? count - w * NE : NE;
        bad = -1;
        got = '0;
        want = '0;
        for (int k = 0; k < n; k++) begin
          if (wr_data[w][FW-1-k*EW -: EW] !== 64'(base + w * NE + k) && bad < 0) begin
            bad = k;
            got = wr_data[w][FW-1-k*EW -: EW];
            want = 64'(base + w * NE + k);
          end
        end
        checks++;
        if (bad >= 0 || wr_last[w] !== (w == nwr - 1) ||
            wr_bnd[w] !== ((w == nwr - 1) ? 8'(n) : 8'd0)) begin
          failures++;
          $display("FAIL %s write %0d: slot %0d got %0d want %0d, last %0b want %0b, bounds %0d want %0d",
                   name, w, bad, got, want, wr_last[w], (w == nwr - 1),
                   wr_bnd[w], (w == nwr - 1) ? n : 0);
        end
      end
    end
    checks++;
    if (full_viol != 0) begin
      failures++;
      $display("FAIL %s wrreq_while_full: got %0d want 0", name, full_viol);
    end
  endtask

  task automatic run_cmd(input string name, input int base, input int count);
    bit done, was;
    clear_logs();
    g_base = 32'(base);
    g_count = 32'(count);
    g_cmd_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      was = (accepted > 0);
      cycle();
      if (was && cmd_ready) done = 1'b1;
    end
    g_cmd_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s completion: cmd_ready did not return, want 1", name);
    end else begin
      score(name, base, count);
    end
  endtask

  task automatic test_reset();
    g_rst = 1'b1;
    repeat (2) cycle();
    g_rst = 1'b0;
    cycle();
    checks++;
    if ({cmd_ready, mem_req_valid, mem_rsp_ready, buf_wrreq, buf_last} !== 5'b10000) begin
      failures++;
      $display("FAIL reset ctl: got %b want 10000",
               {cmd_ready, mem_req_valid, mem_rsp_ready, buf_wrreq, buf_last});
    end
    checks++;
    if (buf_bounds !== 8'd0 || mem_req_addr !== 32'd0) begin
      failures++;
      $display("FAIL reset bounds/addr: got %0d/%0d want 0/0", buf_bounds, mem_req_addr);
    end
    checks++;
    if (buf_wdata !== '0) begin
      failures++;
      $display("FAIL reset wdata: got %h want 0", buf_wdata);
    end
  endtask

  task automatic test_aligned();
    run_cmd("aligned", 16, 16);
  endtask

  task automatic test_partial();
    run_cmd("partial", 3, 5);
  endtask

  task automatic test_unaligned();
    run_cmd("unaligned", 5, 10);
  endtask

  task automatic test_noflush();
    run_cmd("noflush", 6, 4);
  endtask

  task automatic test_zero();
    clear_logs();
    g_base = 32'd7;
    g_count = 32'd0;
    g_cmd_valid = 1'b1;
    cycle();
    checks++;
    if (accepted != 1) begin
      failures++;
      $display("FAIL zero accept: got %0d want 1", accepted);
    end
    cycle();
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero ready_c1: got %b want 0", cmd_ready);
    end
    cycle();
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero ready_c2: got %b want 1", cmd_ready);
    end
    g_cmd_valid = 1'b0;
    repeat (3) cycle();
    checks++;
    if (req_log.size() != 0 || wr_data.size() != 0) begin
      failures++;
      $display("FAIL zero traffic: got %0d req %0d wr want 0 0",
               req_log.size(), wr_data.size());
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bit done;
    g_rnd = 1'b0;
    g_rsp_en = 1'b0;
    clear_logs();
    g_base = 32'd0;
    g_count = 32'd96;
    g_cmd_valid = 1'b1;
    repeat (20) cycle();
    checks++;
    if (req_log.size() != 8) begin
      failures++;
      $display("FAIL credit count: got %0d want 8", req_log.size());
    end
    checks++;
    if (mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL credit req_valid: got %b want 0", mem_req_valid);
    end
    g_rsp_en = 1'b1;
    repeat (4) cycle();
    g_full = 1'b1;
    bad = 0;
    repeat (5) begin
      cycle();
      if (buf_wrreq !== 1'b0 || mem_rsp_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL full stall: got %0d active cycles want 0", bad);
    end
    g_full = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      cycle();
      if (cmd_ready) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL backpressure completion: cmd_ready did not return, want 1");
    end else begin
      score("backpressure", 0, 96);
    end
    g_rnd = 1'b1;
  endtask

  task automatic test_mid_reset();
    int nwr;
    g_rnd = 1'b0;
    clear_logs();
    g_base = 32'd5;
    g_count = 32'd10;
    g_cmd_valid = 1'b1;
    for (int i = 0; i < 50 && rsp_seen == 0; i++) cycle();
    checks++;
    if (rsp_seen != 1) begin
      failures++;
      $display("FAIL midrst first_rsp: got %0d want 1", rsp_seen);
    end
    nwr = wr_data.size();
    g_rst = 1'b1;
    cycle();
    g_rst = 1'b0;
    cycle();
    checks++;
    if ({cmd_ready, mem_req_valid, mem_rsp_ready, buf_wrreq, buf_last} !== 5'b10000 ||
        buf_bounds !== 8'd0 || mem_req_addr !== 32'd0 || buf_wdata !== '0) begin
      failures++;
      $display("FAIL midrst outputs: got ctl %b bounds %0d addr %0d want 10000 0 0",
               {cmd_ready, mem_req_valid, mem_rsp_ready, buf_wrreq, buf_last},
               buf_bounds, mem_req_addr);
    end
    repeat (5) cycle();
    checks++;
    if (wr_data.size() != nwr) begin
      failures++;
      $display("FAIL midrst writes: got %0d want %0d", wr_data.size(), nwr);
    end
    g_rnd = 1'b1;
    run_cmd("after_reset", 8, 8);
  endtask

  task automatic test_random();
    int base, count;
    g_rnd_full = 1'b1;
    for (int t = 0; t < 30; t++) begin
      base = int'($urandom_range(0, 300));
      count = (t % 5 == 0) ? int'($urandom_range(40, 130))
                           : int'($urandom_range(0, 40));
      run_cmd($sformatf("random%0d", t), base, count);
    end
    g_rnd_full = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_base = '0;
    cmd_count = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    buf_full = 1'b0;
    test_reset();
    test_aligned();
    test_partial();
    test_unaligned();
    test_noflush();
    test_zero();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
